// File: rtl/o_feature_store_pkg.sv
// Shared definitions for the output feature store engine.
// Holds the default bus/address/count widths and the FSM state encodings
// used by o_feature_store. No ports; imported by the RTL files.
package o_feature_store_pkg;

   localparam int DATA_BUS_WIDTH = 128;
   localparam int EXT_ADDR_WIDTH = 16;
   localparam int BUF_ADDR_WIDTH = 8;
   localparam int CNT_WIDTH      = 8;

   localparam int STATE_WIDTH    = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/o_feature_store_skid_fifo.sv
// Two-entry synchronous skid FIFO between the buffer read port and the
// external write port.
// Ports: clk, rst (sync, active high), push/din write side, pop/dout read
// side, empty flag and occupancy count (0..2).
module o_feature_store_skid_fifo #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= {WIDTH{1'b0}};
         mem_q[1] <= {WIDTH{1'b0}};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == 2'd0);
   assign count = count_q;

endmodule

// File: rtl/o_feature_store.sv
// Output feature write-back engine.
// On store_enable it reads store_counter consecutive words from the output
// feature buffer (starting at src_addr) and writes them to the external bus
// at incrementing addresses (starting at dst_addr), honouring o_ready.
// Ports: clk, rst (sync, active high); command: store_enable, src_addr,
// dst_addr, store_counter; buffer read: buf_rd_en, buf_rd_addr, buf_rd_data;
// external write: o_data, o_addr, o_wr_en, o_ready; status: store_busy,
// store_done.
module o_feature_store #(
   parameter int DATA_BUS_WIDTH = o_feature_store_pkg::DATA_BUS_WIDTH,
   parameter int EXT_ADDR_WIDTH = o_feature_store_pkg::EXT_ADDR_WIDTH,
   parameter int BUF_ADDR_WIDTH = o_feature_store_pkg::BUF_ADDR_WIDTH,
   parameter int CNT_WIDTH      = o_feature_store_pkg::CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      store_enable,
   input  logic [BUF_ADDR_WIDTH-1:0] src_addr,
   input  logic [EXT_ADDR_WIDTH-1:0] dst_addr,
   input  logic [CNT_WIDTH-1:0]      store_counter,
   output logic                      buf_rd_en,
   output logic [BUF_ADDR_WIDTH-1:0] buf_rd_addr,
   input  logic [DATA_BUS_WIDTH-1:0] buf_rd_data,
   output logic [DATA_BUS_WIDTH-1:0] o_data,
   output logic [EXT_ADDR_WIDTH-1:0] o_addr,
   output logic                      o_wr_en,
   input  logic                      o_ready,
   output logic                      store_busy,
   output logic                      store_done
);

   import o_feature_store_pkg::*;

   logic [1:0]                state_q, state_d;
   logic [BUF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [EXT_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_WIDTH-1:0]      rd_left_q, rd_left_d;
   logic [CNT_WIDTH-1:0]      wr_left_q, wr_left_d;
   logic                      outstanding_q, outstanding_d;

   logic                      push_s;
   logic                      pop_s;
   logic                      rd_en_s;
   logic                      fifo_empty_s;
   logic [1:0]                fifo_count_s;
   logic [2:0]                credit_s;
   logic [DATA_BUS_WIDTH-1:0] fifo_dout_s;

   // Read issue credit, FIFO handshakes and FSM/counter next state.
   always_comb begin
      pop_s    = ~fifo_empty_s & o_ready;
      // Read data arrives the cycle after the read, so the in-flight flag
      // doubles as the FIFO push strobe.
      push_s   = outstanding_q;
      // Slots already claimed after this cycle's pop; a new read may only
      // be issued while fewer than two are claimed, so the FIFO never
      // overflows.
      credit_s = {2'b00, outstanding_q} + {1'b0, fifo_count_s} - {2'b00, pop_s};
      rd_en_s  = (state_q == ST_RUN) &&
                 (rd_left_q != {CNT_WIDTH{1'b0}}) &&
                 (credit_s < 3'd2);

      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      wr_addr_d     = wr_addr_q;
      rd_left_d     = rd_left_q;
      wr_left_d     = wr_left_q;
      outstanding_d = rd_en_s;

      case (state_q)
         ST_IDLE: begin
            if (store_enable) begin
               rd_addr_d = src_addr;
               wr_addr_d = dst_addr;
               rd_left_d = store_counter;
               wr_left_d = store_counter;
               if (store_counter == {CNT_WIDTH{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (rd_en_s) begin
               rd_addr_d = rd_addr_q + BUF_ADDR_WIDTH'(1);
               rd_left_d = rd_left_q - CNT_WIDTH'(1);
            end else begin
               rd_addr_d = rd_addr_q;
               rd_left_d = rd_left_q;
            end
            if (pop_s) begin
               wr_addr_d = wr_addr_q + EXT_ADDR_WIDTH'(1);
               wr_left_d = wr_left_q - CNT_WIDTH'(1);
               if (wr_left_q == CNT_WIDTH'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               wr_addr_d = wr_addr_q;
               wr_left_d = wr_left_q;
               state_d   = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, address counters and in-flight flag with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rd_addr_q     <= {BUF_ADDR_WIDTH{1'b0}};
         wr_addr_q     <= {EXT_ADDR_WIDTH{1'b0}};
         rd_left_q     <= {CNT_WIDTH{1'b0}};
         wr_left_q     <= {CNT_WIDTH{1'b0}};
         outstanding_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         wr_addr_q     <= wr_addr_d;
         rd_left_q     <= rd_left_d;
         wr_left_q     <= wr_left_d;
         outstanding_q <= outstanding_d;
      end
   end

   o_feature_store_skid_fifo #(
      .WIDTH (DATA_BUS_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (buf_rd_data),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Head data and write address only change on a transfer, so both are
   // held while the sink stalls.
   assign buf_rd_en   = rd_en_s;
   assign buf_rd_addr = rd_addr_q;
   assign o_wr_en     = ~fifo_empty_s;
   assign o_data      = fifo_dout_s;
   assign o_addr      = wr_addr_q;
   assign store_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign store_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_o_feature_store.sv
// Directed testbench for o_feature_store.
module tb_o_feature_store;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         store_enable = 1'b0;
   logic [7:0]   src_addr = 8'h00;
   logic [15:0]  dst_addr = 16'h0000;
   logic [7:0]   store_counter = 8'h00;
   logic         buf_rd_en;
   logic [7:0]   buf_rd_addr;
   logic [127:0] buf_rd_data;
   logic [127:0] o_data;
   logic [15:0]  o_addr;
   logic         o_wr_en;
   logic         o_ready = 1'b1;
   logic         store_busy;
   logic         store_done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int cmd_cyc = 0;

   // monitor state
   logic [7:0]   rd_q[$];
   logic [15:0]  xa_q[$];
   logic [127:0] xd_q[$];
   int first_rd, last_rd, first_wr, wr_cyc, stall, hold_err, done_n, done_at, max_fifo;
   logic [15:0]  stall_addr;
   logic         prev_stall;
   logic [15:0]  prev_addr;
   logic [127:0] prev_data;
   logic         mon_clr = 1'b0;
   int mode = 0;
   int bp_cnt = 0;

   o_feature_store dut (
      .clk           (clk),
      .rst           (rst),
      .store_enable  (store_enable),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .store_counter (store_counter),
      .buf_rd_en     (buf_rd_en),
      .buf_rd_addr   (buf_rd_addr),
      .buf_rd_data   (buf_rd_data),
      .o_data        (o_data),
      .o_addr        (o_addr),
      .o_wr_en       (o_wr_en),
      .o_ready       (o_ready),
      .store_busy    (store_busy),
      .store_done    (store_done)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] data_of(input logic [7:0] a);
      return {8{a, ~a}};
   endfunction

   // cycle counter
   always_ff @(posedge clk) cyc <= cyc + 1;

   // buffer model: one-cycle read latency
   always_ff @(posedge clk) begin
      if (buf_rd_en) buf_rd_data <= data_of(buf_rd_addr);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // negedge monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mon_clr) begin
            rd_q.delete(); xa_q.delete(); xd_q.delete();
            first_rd = -1; last_rd = -1; first_wr = -1; wr_cyc = 0;
            stall = 0; hold_err = 0; done_n = 0; done_at = -1; max_fifo = 0;
            stall_addr = 16'h0000; prev_stall = 1'b0;
         end else begin
            if (buf_rd_en) begin
               rd_q.push_back(buf_rd_addr);
               if (first_rd < 0) first_rd = cyc;
               last_rd = cyc;
            end
            if (o_wr_en) begin
               wr_cyc++;
               if (first_wr < 0) first_wr = cyc;
            end
            if (o_wr_en && o_ready) begin
               xa_q.push_back(o_addr);
               xd_q.push_back(o_data);
            end
            if (prev_stall && (!o_wr_en || o_addr !== prev_addr || o_data !== prev_data)) hold_err++;
            if (o_wr_en && !o_ready) begin
               stall++;
               stall_addr = o_addr;
            end
            prev_stall = o_wr_en && !o_ready;
            prev_addr  = o_addr;
            prev_data  = o_data;
            if (store_done) begin
               done_n++;
               if (done_at < 0) done_at = cyc;
            end
            if (int'(dut.u_fifo.count_q) > max_fifo) max_fifo = int'(dut.u_fifo.count_q);
         end
      end
   end

   function automatic int rel(input int c);
      return c - cmd_cyc + 1;
   endfunction

   task automatic issue(input logic [7:0] s, input logic [15:0] d, input logic [7:0] n);
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      src_addr = s; dst_addr = d; store_counter = n; store_enable = 1'b1;
      @(posedge clk);
      #1;
      cmd_cyc = cyc;
      store_enable = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bp_cnt = 0;
      for (int i = 0; i < budget && done_n == 0; i++) begin
         @(posedge clk);
         #1;
         case (mode)
            1: begin
               if (xa_q.size() == 1 && bp_cnt < 5) begin
                  o_ready = 1'b0;
                  bp_cnt++;
               end else begin
                  o_ready = 1'b1;
               end
            end
            2: o_ready = ~o_ready;
            default: o_ready = 1'b1;
         endcase
      end
      check({tag, "_timeout"}, 128'(done_n != 0), 128'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      o_ready = 1'b1;
      check({tag, "_done_count"}, 128'(done_n), 128'd1);
   endtask

   task automatic verify_xfers(input string tag, input logic [7:0] s, input logic [15:0] d, input int n);
      check({tag, "_xfer_count"}, 128'(xa_q.size()), 128'(n));
      for (int i = 0; i < n && i < xa_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 128'(xa_q[i]), 128'(16'(d + 16'(i))));
         check($sformatf("%s_data%0d", tag, i), xd_q[i], data_of(8'(s + 8'(i))));
      end
   endtask

   task automatic verify_reads(input string tag, input logic [7:0] s, input int n);
      check({tag, "_rd_count"}, 128'(rd_q.size()), 128'(n));
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
         check($sformatf("%s_rdaddr%0d", tag, i), 128'(rd_q[i]), 128'(8'(s + 8'(i))));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_en"},   128'(buf_rd_en),   128'd0);
      check({tag, "_rd_addr"}, 128'(buf_rd_addr), 128'd0);
      check({tag, "_o_data"},  o_data,            128'd0);
      check({tag, "_o_addr"},  128'(o_addr),      128'd0);
      check({tag, "_o_wr_en"}, 128'(o_wr_en),     128'd0);
      check({tag, "_busy"},    128'(store_busy),  128'd0);
      check({tag, "_done"},    128'(store_done),  128'd0);
   endtask

   initial begin
      int snap_x;
      int snap_w;

      // reset
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // basic store: 4 words, sink always ready
      mode = 0;
      issue(8'h10, 16'h0200, 8'd4);
      check("basic_busy", 128'(store_busy), 128'd1);
      wait_done("basic", 100);
      check("basic_first_rd", 128'(rel(first_rd)), 128'd1);
      check("basic_last_rd",  128'(rel(last_rd)),  128'd4);
      check("basic_first_wr", 128'(rel(first_wr)), 128'd3);
      check("basic_wr_cyc",   128'(wr_cyc),        128'd4);
      check("basic_done_at",  128'(rel(done_at)),  128'd7);
      verify_reads("basic", 8'h10, 4);
      verify_xfers("basic", 8'h10, 16'h0200, 4);

      // back-pressure on the second word for 5 cycles
      mode = 1;
      issue(8'h50, 16'h0200, 8'd3);
      wait_done("bp", 100);
      check("bp_stall_cycles", 128'(stall),      128'd5);
      check("bp_stall_addr",   128'(stall_addr), 128'h0201);
      check("bp_hold_err",     128'(hold_err),   128'd0);
      check("bp_fifo_le2",     128'(max_fifo <= 2), 128'd1);
      verify_reads("bp", 8'h50, 3);
      verify_xfers("bp", 8'h50, 16'h0200, 3);

      // zero count: DONE is entered at the command edge, so the pulse is in
      // the first cycle after it and nothing is read or written
      mode = 0;
      issue(8'h33, 16'h0100, 8'd0);
      wait_done("zero", 20);
      check("zero_rd_count", 128'(rd_q.size()), 128'd0);
      check("zero_wr_cyc",   128'(wr_cyc),      128'd0);
      check("zero_done_at",  128'(rel(done_at)), 128'd1);

      // wrap-around on both address spaces
      issue(8'hFE, 16'hFFFF, 8'd3);
      wait_done("wrap", 100);
      verify_reads("wrap", 8'hFE, 3);
      verify_xfers("wrap", 8'hFE, 16'hFFFF, 3);

      // second command during RUN is ignored
      issue(8'h30, 16'h0400, 8'd5);
      @(posedge clk);
      #1;
      src_addr = 8'h80; dst_addr = 16'h0900; store_counter = 8'd2; store_enable = 1'b1;
      @(posedge clk);
      #1;
      store_enable = 1'b0;
      wait_done("busy_cmd", 100);
      verify_reads("busy_cmd", 8'h30, 5);
      verify_xfers("busy_cmd", 8'h30, 16'h0400, 5);

      // reset mid-RUN aborts without done or further writes
      issue(8'h40, 16'h1000, 8'd8);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_zero("midrst");
      snap_x = xa_q.size();
      snap_w = wr_cyc;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      check("midrst_no_xfer", 128'(xa_q.size()), 128'(snap_x));
      check("midrst_no_wr",   128'(wr_cyc),      128'(snap_w));
      check("midrst_no_done", 128'(done_n),      128'd0);
      issue(8'h20, 16'h0300, 8'd2);
      wait_done("after_rst", 100);
      verify_reads("after_rst", 8'h20, 2);
      verify_xfers("after_rst", 8'h20, 16'h0300, 2);

      // alternating ready, maximum count
      mode = 2;
      issue(8'h01, 16'h7000, 8'd255);
      wait_done("alt", 2000);
      check("alt_fifo_le2", 128'(max_fifo <= 2), 128'd1);
      verify_xfers("alt", 8'h01, 16'h7000, 255);
      mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
